fm_guard_writer: RTL and testbench
==================================

FM_GUARD_WRITER -- requirements
Module: fm_guard_writer

Interface
REQ-001 The block SHALL have parameter FM_ADDR_W, default 12, meaning the feature-map SRAM word-address width.
REQ-002 The block SHALL have parameter GD_ADDR_W, default 10, meaning the guard SRAM word-address width.
REQ-003 The block SHALL use one clock, clk, and reset is asynchronous and active-high, rst.
REQ-004 The block SHALL have these ports (name, direction, width, meaning):
  clk  in  1  clock
  rst  in  1  async active-high reset
  ctrl_valid  in  1  job request
  ctrl_ready  out  1  idle, job accepted when ctrl_valid && ctrl_ready
  ctrl_finish  out  1  one-cycle job-done pulse
  fm_base_i  in  FM_ADDR_W  first FM word address
  gd_base_i  in  GD_ADDR_W  first guard word address
  data_i  in  8  byte from the upstream write-back stage
  data_valid_i  in  1  data_i qualifier
  guard_i  in  6  guard vector from write-back
  guard_valid_i  in  1  guard_i qualifier
  flush_i  in  1  upstream ctrl_finish (end of stream)
  fm_wr_en  out  1  FM SRAM write strobe
  fm_wr_addr  out  FM_ADDR_W  FM write address
  fm_wr_data  out  64  packed FM word
  gd_wr_en  out  1  guard SRAM write strobe
  gd_wr_addr  out  GD_ADDR_W  guard write address
  gd_wr_data  out  48  packed guard word (8 vectors)
  err_o  out  1  sticky protocol error

Function
REQ-005 The block SHALL implement states IDLE, RUN, FLUSH and FIN.
REQ-006 Transitions SHALL be: IDLE->RUN on ctrl_valid && ctrl_ready; RUN->FLUSH when flush_i=1; FLUSH->FIN unconditionally; FIN->IDLE unconditionally.
REQ-007 ctrl_ready SHALL be 1 only in IDLE.
REQ-008 On job accept, the block SHALL latch fm_base_i and gd_base_i into the write pointers and clear the byte and vector counters.
REQ-009 In RUN, each data_valid_i byte SHALL be placed at byte lane byte_cnt (first byte in [7:0]), and byte_cnt SHALL increment modulo 8.
REQ-010 When the 8th byte is accepted at edge N, the full word SHALL appear on fm_wr_data with fm_wr_en=1 for exactly the cycle after N, at the current FM pointer.
REQ-011 The FM pointer SHALL then increment, wrapping from 2^FM_ADDR_W-1 to 0.
REQ-012 Guard vectors SHALL pack the same way: 6-bit lanes, first vector in [5:0], 8 vectors per word, with the gd_* write and pointer increment following the same timing and wrap rules as REQ-010/011.
REQ-013 Byte and guard packing SHALL be independent; FM and guard writes in the same cycle are legal.
REQ-014 A byte or vector accepted in the same cycle as flush_i SHALL be packed before the flush takes effect.
REQ-015 On the FLUSH edge, a nonzero partial FM word SHALL be written in the FIN cycle with unused lanes set to zero; a partial guard word SHALL be handled the same way.
REQ-016 A zero count at flush SHALL produce no write.
REQ-017 ctrl_finish SHALL be 1 for exactly the FIN cycle.
REQ-018 data_valid_i, guard_valid_i or flush_i asserted outside RUN (FLUSH of the current cycle included, REQ-014 excepted) SHALL be ignored and SHALL set err_o.
REQ-019 err_o SHALL clear only on reset or on job accept.
REQ-020 All outputs SHALL be registered.
REQ-021 fm_wr_data and gd_wr_data SHALL hold their value when the corresponding strobe is 0.

Reset
REQ-022 While rst=1, the block SHALL hold state=IDLE, ctrl_ready=1, ctrl_finish=0, fm_wr_en=0, gd_wr_en=0, err_o=0, and all data, address, counter and pointer registers at 0.
REQ-023 Reset asserted mid-job SHALL abort the job immediately with no write and no ctrl_finish.

Verification
REQ-024 fm_base=0x010, 16 bytes 0x01..0x10 then flush -> fm writes: addr 0x010 data 0x0807060504030201, then addr 0x011 data 0x100F0E0D0C0B0A09; no partial write; ctrl_finish 2 cycles after flush.
REQ-025 3 bytes 0xAA,0xBB,0xCC then flush -> single write 0x0000000000CCBBAA in the FIN cycle.
REQ-026 fm_base=0xFFF, 16 bytes -> writes at addresses 0xFFF then 0x000.
REQ-027 9 guard vectors 6'h01..6'h09, the 9th coinciding with flush_i -> full guard word written, then a partial word 48'h000000000009.
REQ-028 data_valid_i pulsed in IDLE -> no write and err_o=1; next job accept -> err_o=0.
REQ-029 rst pulsed after 5 bytes -> no fm write, ctrl_ready=1, and the next job starts packing at lane 0.

Source files
------------

// File: rtl/fm_guard_writer.sv
// Packs write-back bytes into 64-bit FM words and 6-bit guard vectors into 48-bit guard words,
// then streams the packed words to their SRAMs. Each job ends with a flush of any partial words.
module fm_guard_writer #(
    parameter int FM_ADDR_W = 12,
    parameter int GD_ADDR_W = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ctrl_valid,
    output logic                 ctrl_ready,
    output logic                 ctrl_finish,
    input  logic [FM_ADDR_W-1:0] fm_base_i,
    input  logic [GD_ADDR_W-1:0] gd_base_i,
    input  logic [7:0]           data_i,
    input  logic                 data_valid_i,
    input  logic [5:0]           guard_i,
    input  logic                 guard_valid_i,
    input  logic                 flush_i,
    output logic                 fm_wr_en,
    output logic [FM_ADDR_W-1:0] fm_wr_addr,
    output logic [63:0]          fm_wr_data,
    output logic                 gd_wr_en,
    output logic [GD_ADDR_W-1:0] gd_wr_addr,
    output logic [47:0]          gd_wr_data,
    output logic                 err_o
);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, FIN} state_t;

    state_t                 state, state_nxt;
    logic [2:0]             byte_cnt, vec_cnt;
    logic [63:0]            fm_acc, fm_pack;
    logic [47:0]            gd_acc, gd_pack;
    logic [FM_ADDR_W-1:0]   fm_ptr;
    logic [GD_ADDR_W-1:0]   gd_ptr;
    logic                   accept, byte_in, vec_in, misuse;
    logic [5:0]             fm_lane, gd_lane;

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE:    if (ctrl_valid) begin
                         state_nxt = RUN;
                         accept    = 1'b1;
                     end
            RUN:     if (flush_i) state_nxt = FLUSH;
            FLUSH:   state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Inputs only count in RUN; the flush cycle itself is still RUN, so its byte/vector is packed.
    always_comb begin
        byte_in = (state == RUN) && data_valid_i;
        vec_in  = (state == RUN) && guard_valid_i;
        misuse  = (state != RUN) && (data_valid_i || guard_valid_i || flush_i);
        fm_lane = {byte_cnt, 3'b000};
        gd_lane = {3'b000, vec_cnt} * 6'd6;
        fm_pack = fm_acc;
        fm_pack[fm_lane +: 8] = data_i;
        gd_pack = gd_acc;
        gd_pack[gd_lane +: 6] = guard_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_ready  <= 1'b1;
            ctrl_finish <= 1'b0;
            err_o       <= 1'b0;
            fm_wr_en    <= 1'b0;
            fm_wr_addr  <= '0;
            fm_wr_data  <= '0;
            gd_wr_en    <= 1'b0;
            gd_wr_addr  <= '0;
            gd_wr_data  <= '0;
            byte_cnt    <= '0;
            vec_cnt     <= '0;
            fm_acc      <= '0;
            gd_acc      <= '0;
            fm_ptr      <= '0;
            gd_ptr      <= '0;
        end else begin
            fm_wr_en    <= 1'b0;
            gd_wr_en    <= 1'b0;
            ctrl_ready  <= (state_nxt == IDLE);
            ctrl_finish <= (state == FLUSH);
            err_o       <= misuse | (err_o & ~accept);

            if (accept) begin
                fm_ptr   <= fm_base_i;
                gd_ptr   <= gd_base_i;
                byte_cnt <= '0;
                vec_cnt  <= '0;
                fm_acc   <= '0;
                gd_acc   <= '0;
            end

            if (byte_in) begin
                byte_cnt <= byte_cnt + 3'd1;
                if (byte_cnt == 3'd7) begin
                    fm_wr_en   <= 1'b1;
                    fm_wr_addr <= fm_ptr;
                    fm_wr_data <= fm_pack;
                    fm_ptr     <= fm_ptr + 1'b1;
                    fm_acc     <= '0;
                end else begin
                    fm_acc <= fm_pack;
                end
            end

            if (vec_in) begin
                vec_cnt <= vec_cnt + 3'd1;
                if (vec_cnt == 3'd7) begin
                    gd_wr_en   <= 1'b1;
                    gd_wr_addr <= gd_ptr;
                    gd_wr_data <= gd_pack;
                    gd_ptr     <= gd_ptr + 1'b1;
                    gd_acc     <= '0;
                end else begin
                    gd_acc <= gd_pack;
                end
            end

            // Partial words: unused lanes are already zero because the accumulators clear after each full word.
            if (state == FLUSH) begin
                if (byte_cnt != 3'd0) begin
                    fm_wr_en   <= 1'b1;
                    fm_wr_addr <= fm_ptr;
                    fm_wr_data <= fm_acc;
                    fm_ptr     <= fm_ptr + 1'b1;
                    byte_cnt   <= '0;
                    fm_acc     <= '0;
                end
                if (vec_cnt != 3'd0) begin
                    gd_wr_en   <= 1'b1;
                    gd_wr_addr <= gd_ptr;
                    gd_wr_data <= gd_acc;
                    gd_ptr     <= gd_ptr + 1'b1;
                    vec_cnt    <= '0;
                    gd_acc     <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_fm_guard_writer.sv
// Directed and randomized jobs for fm_guard_writer, checked against a word-list model of the packing rules.
module tb_fm_guard_writer;

    localparam int FW = 12;
    localparam int GW = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ctrl_valid = 1'b0;
    logic          ctrl_ready, ctrl_finish;
    logic [FW-1:0] fm_base_i = '0;
    logic [GW-1:0] gd_base_i = '0;
    logic [7:0]    data_i = '0;
    logic          data_valid_i = 1'b0;
    logic [5:0]    guard_i = '0;
    logic          guard_valid_i = 1'b0;
    logic          flush_i = 1'b0;
    logic          fm_wr_en, gd_wr_en, err_o;
    logic [FW-1:0] fm_wr_addr;
    logic [63:0]   fm_wr_data;
    logic [GW-1:0] gd_wr_addr;
    logic [47:0]   gd_wr_data;

    fm_guard_writer #(.FM_ADDR_W(FW), .GD_ADDR_W(GW)) dut (
        .clk(clk), .rst(rst), .ctrl_valid(ctrl_valid), .ctrl_ready(ctrl_ready),
        .ctrl_finish(ctrl_finish), .fm_base_i(fm_base_i), .gd_base_i(gd_base_i),
        .data_i(data_i), .data_valid_i(data_valid_i), .guard_i(guard_i),
        .guard_valid_i(guard_valid_i), .flush_i(flush_i), .fm_wr_en(fm_wr_en),
        .fm_wr_addr(fm_wr_addr), .fm_wr_data(fm_wr_data), .gd_wr_en(gd_wr_en),
        .gd_wr_addr(gd_wr_addr), .gd_wr_data(gd_wr_data), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    // Observed writes, stamped with the cycle they were visible in.
    int            ofm_cyc[$];
    logic [FW-1:0] ofm_addr[$];
    logic [63:0]   ofm_data[$];
    int            ogd_cyc[$];
    logic [GW-1:0] ogd_addr[$];
    logic [47:0]   ogd_data[$];

    always @(negedge clk) begin
        if (fm_wr_en) begin
            ofm_cyc.push_back(cyc); ofm_addr.push_back(fm_wr_addr); ofm_data.push_back(fm_wr_data);
        end
        if (gd_wr_en) begin
            ogd_cyc.push_back(cyc); ogd_addr.push_back(gd_wr_addr); ogd_data.push_back(gd_wr_data);
        end
    end

    // Job content and the cycles each item was driven in.
    logic [7:0] bq[$];
    logic [5:0] vq[$];
    int         bcyc[$];
    int         vcyc[$];
    int         fcyc;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_obs();
        ofm_cyc.delete(); ofm_addr.delete(); ofm_data.delete();
        ogd_cyc.delete(); ogd_addr.delete(); ogd_data.delete();
    endtask

    task automatic compare_fm(input int fb);
        int n = bq.size();
        int nw = (n + 7) / 8;
        check("fm_write_count", ofm_cyc.size(), nw);
        for (int w = 0; w < nw && w < ofm_cyc.size(); w++) begin
            logic [63:0] d = '0;
            bit full = (w * 8 + 8 <= n);
            for (int i = w * 8; i < n && i < w * 8 + 8; i++) d[(i % 8) * 8 +: 8] = bq[i];
            check("fm_data", ofm_data[w], d);
            check("fm_addr", ofm_addr[w], (fb + w) % (1 << FW));
            check("fm_cycle", ofm_cyc[w], full ? bcyc[w * 8 + 7] + 1 : fcyc + 2);
        end
    endtask

    task automatic compare_gd(input int gb);
        int n = vq.size();
        int nw = (n + 7) / 8;
        check("gd_write_count", ogd_cyc.size(), nw);
        for (int w = 0; w < nw && w < ogd_cyc.size(); w++) begin
            logic [47:0] d = '0;
            bit full = (w * 8 + 8 <= n);
            for (int i = w * 8; i < n && i < w * 8 + 8; i++) d[(i % 8) * 6 +: 6] = vq[i];
            check("gd_data", ogd_data[w], d);
            check("gd_addr", ogd_addr[w], (gb + w) % (1 << GW));
            check("gd_cycle", ogd_cyc[w], full ? vcyc[w * 8 + 7] + 1 : fcyc + 2);
        end
    endtask

    // Runs one complete job from accept to finish; fl_b/fl_v put the last byte/vector in the flush cycle.
    task automatic run_job(input int fb, input int gb, input bit dense, input bit fl_b, input bit fl_v);
        int bi = 0;
        int vi = 0;
        int nb = bq.size() - ((fl_b && bq.size() > 0) ? 1 : 0);
        int nv = vq.size() - ((fl_v && vq.size() > 0) ? 1 : 0);
        int k = 0;
        bcyc.delete(); vcyc.delete(); clear_obs();
        @(negedge clk);
        ctrl_valid = 1'b1; fm_base_i = FW'(fb); gd_base_i = GW'(gb);
        @(negedge clk);
        ctrl_valid = 1'b0;
        check("ready_in_run", ctrl_ready, 1'b0);
        check("err_after_accept", err_o, 1'b0);
        while (bi < nb || vi < nv) begin
            data_valid_i = 1'b0; guard_valid_i = 1'b0;
            if (bi < nb && (dense || $urandom_range(0, 2) != 0)) begin
                data_valid_i = 1'b1; data_i = bq[bi]; bcyc.push_back(cyc); bi++;
            end
            if (vi < nv && (dense || $urandom_range(0, 2) != 0)) begin
                guard_valid_i = 1'b1; guard_i = vq[vi]; vcyc.push_back(cyc); vi++;
            end
            @(negedge clk);
        end
        data_valid_i = 1'b0; guard_valid_i = 1'b0;
        if (bi < bq.size()) begin
            data_valid_i = 1'b1; data_i = bq[bi]; bcyc.push_back(cyc); bi++;
        end
        if (vi < vq.size()) begin
            guard_valid_i = 1'b1; guard_i = vq[vi]; vcyc.push_back(cyc); vi++;
        end
        flush_i = 1'b1; fcyc = cyc;
        @(negedge clk);
        flush_i = 1'b0; data_valid_i = 1'b0; guard_valid_i = 1'b0;
        while (!ctrl_finish && k < 10) begin
            @(negedge clk);
            k++;
        end
        check("finish_cycle", cyc, fcyc + 2);
        @(negedge clk);
        check("finish_one_cycle", ctrl_finish, 1'b0);
        check("ready_after_job", ctrl_ready, 1'b1);
        check("err_end_of_job", err_o, 1'b0);
        compare_fm(fb);
        compare_gd(gb);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset values while rst is held.
        repeat (2) @(negedge clk);
        check("rst_ready", ctrl_ready, 1'b1);
        check("rst_finish", ctrl_finish, 1'b0);
        check("rst_fm_en", fm_wr_en, 1'b0);
        check("rst_gd_en", gd_wr_en, 1'b0);
        check("rst_err", err_o, 1'b0);
        check("rst_fm_data", fm_wr_data, 64'h0);
        check("rst_gd_data", gd_wr_data, 48'h0);
        check("rst_fm_addr", fm_wr_addr, 0);
        rst = 1'b0;
        @(negedge clk);

        // Two full words, dense.
        bq.delete(); vq.delete();
        for (int i = 1; i <= 16; i++) bq.push_back(8'(i));
        run_job(12'h010, 0, 1'b1, 1'b0, 1'b0);
        check("req24_word0", (ofm_data.size() > 0) ? ofm_data[0] : 64'h0, 64'h0807060504030201);
        check("req24_word1", (ofm_data.size() > 1) ? ofm_data[1] : 64'h0, 64'h100F0E0D0C0B0A09);

        // Partial word only.
        bq.delete(); vq.delete();
        bq.push_back(8'hAA); bq.push_back(8'hBB); bq.push_back(8'hCC);
        run_job(12'h123, 0, 1'b1, 1'b0, 1'b0);
        check("req25_partial", (ofm_data.size() > 0) ? ofm_data[0] : 64'h0, 64'h0000000000CCBBAA);

        // FM pointer wrap.
        bq.delete(); vq.delete();
        for (int i = 0; i < 16; i++) bq.push_back(8'($urandom));
        run_job(12'hFFF, 0, 1'b0, 1'b0, 1'b0);
        check("req26_wrap_addr", (ofm_addr.size() > 1) ? ofm_addr[1] : 12'hABC, 12'h000);

        // Nine guard vectors, the last with flush, guard pointer at wrap.
        bq.delete(); vq.delete();
        for (int i = 1; i <= 9; i++) vq.push_back(6'(i));
        run_job(0, 10'h3FF, 1'b1, 1'b0, 1'b1);
        check("req27_partial", (ogd_data.size() > 1) ? ogd_data[1] : 48'h0, 48'h000000000009);

        // Data strobe in IDLE: ignored, sets err; next accept clears it (checked in run_job).
        clear_obs();
        @(negedge clk);
        data_valid_i = 1'b1; data_i = 8'h5A;
        @(negedge clk);
        data_valid_i = 1'b0;
        check("idle_misuse_err", err_o, 1'b1);
        @(negedge clk);
        check("idle_misuse_sticky", err_o, 1'b1);
        check("idle_misuse_nowrite", ofm_cyc.size(), 0);
        bq.delete(); vq.delete();
        for (int i = 0; i < 5; i++) bq.push_back(8'($urandom));
        run_job(12'h200, 10'h010, 1'b1, 1'b1, 1'b0);

        // Reset mid-job after 5 bytes.
        clear_obs();
        @(negedge clk);
        ctrl_valid = 1'b1; fm_base_i = 12'h300;
        @(negedge clk);
        ctrl_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            data_valid_i = 1'b1; data_i = 8'hE0 + 8'(i);
            @(negedge clk);
        end
        data_valid_i = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst_ready", ctrl_ready, 1'b1);
        check("midrst_fm_en", fm_wr_en, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_nowrite", ofm_cyc.size(), 0);
        check("midrst_nofinish", ctrl_finish, 1'b0);
        bq.delete(); vq.delete();
        for (int i = 1; i <= 8; i++) bq.push_back(8'h10 * 8'(i));
        run_job(12'h300, 0, 1'b1, 1'b0, 1'b0);

        // Randomized jobs.
        for (int j = 0; j < 8; j++) begin
            int nb = $urandom_range(0, 30);
            int nv = $urandom_range(0, 20);
            bq.delete(); vq.delete();
            for (int i = 0; i < nb; i++) bq.push_back(8'($urandom));
            for (int i = 0; i < nv; i++) vq.push_back(6'($urandom));
            run_job($urandom_range(0, 4095), $urandom_range(0, 1023), 1'($urandom),
                    1'($urandom), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
